aes_key_schedule: RTL and testbench
===================================

Name: aes_key_schedule

Overview:
- Sequential AES-128 key expansion unit that streams round keys 0..10 to the AddRoundKey stage, which sits directly downstream of the MixColumns stage in the round datapath.
- It computes one round key per accepted transfer and uses a valid/ready handshake so the round controller can stall it.
- It uses the same state packing as the round datapath: word i = bits [i*32+:32], and byte 0 of each word is in bits [7:0].

Parameters:
- NR, 10, number of rounds; keys 0..NR are emitted (fixed at 10 for AES-128 and must not be overridden).

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous, active-low reset.
- key_in  input  128  cipher key, packed as above; sampled on start handshake.
- start_valid  input  1  request a new expansion.
- start_ready  output  1  high only in IDLE.
- rk_data  output  128  current round key.
- rk_round  output  4  index of rk_data, range 0..10.
- rk_valid  output  1  rk_data/rk_round are valid.
- rk_ready  input  1  consumer accepts the current round key.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after round key 10 is accepted.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, rk_data=0, rk_round=0, rcon=8'h01, rk_valid=0, busy=0, done=0, start_ready=1 once released.
- FSM has two states, IDLE and RUN.
- IDLE -> RUN when start_valid && start_ready. Next cycle: rk_data=key_in, rk_round=0, rcon=8'h01, rk_valid=1, busy=1. Start-to-first-key latency is 1 cycle.
- In RUN, rk_valid=1 continuously. rk_data and rk_round hold stable while rk_ready=0, for any stall length.
- On a handshake (rk_valid && rk_ready) with rk_round<10, the next key is computed from the current rk_data and rcon:
  - t = SubWord(RotWord(w3)) ^ {24'h0, rcon}.
  - RotWord = {w3[7:0], w3[31:8]}.
  - SubWord applies the S-box to each byte.
  - w0' = w0^t, w1' = w1^w0', w2' = w2^w1', w3' = w3^w2'.
  - rk_data <= {w3',w2',w1',w0'}, rk_round <= rk_round+1, rcon <= xtime(rcon).
  - rcon sequence: 01,02,04,08,10,20,40,80,1b,36.
- Throughput: one key per cycle when rk_ready is held high, so 11 keys take 11 consecutive cycles.
- On the handshake with rk_round==10: next cycle state=IDLE, rk_valid=0, busy=0, done=1 for exactly one cycle. rk_data holds key 10 and rk_round holds 10.
- start_valid during RUN is ignored because start_ready=0. Back-to-back operation: start is accepted in the same cycle that done is high.
- rk_ready asserted while rk_valid=0 has no effect.
- Reset asserted mid-expansion aborts immediately to the reset values. No partial state survives.
- rk_round never exceeds 10. rcon is not advanced past 8'h36.

Optional Feature:
- Macro: AES_KEY_SCHEDULE_CACHE_EN.
- Defined:
  - Adds an 11x128 register array that is written with each round key at its handshake.
  - Adds a readback port pair: rd_idx input 4 and rd_key output 128, combinational read.
  - Adds cache_valid output 1, set on done and cleared on reset or on a new start.
  - rd_idx>10 returns 0. This lets decryption read keys in reverse order.
- Not defined: none of these ports or registers exist, and behaviour is otherwise identical.

Decomposition:
- Package aes_pkg:
  - AES_NR=10 and the rcon reset value 8'h01.
  - xtime function: shift left by 1; if bit7 was set, XOR with 8'h1b.
  - typedefs: aes_word_t (32 bits), aes_state_t (128 bits).
- Sub-module aes_sbox: 8-bit combinational forward S-box, instantiated 4 times for SubWord. It is shared with the SubBytes stage.

Test Plan:
- FIPS-197 key, bytes 2b 7e 15 16 28 ae d2 a6 ab f7 15 88 09 cf 4f 3c (byte 0 = key_in[7:0]=8'h2b), with rk_ready=1 -> round 1 bytes a0 fa fe 17 88 54 2c b1 23 a3 39 39 2a 6c 76 05; round 10 bytes d0 14 f9 a8 c9 ee 25 89 e1 3f 0c c8 b6 63 0c a6; 11 consecutive valid cycles, then a done pulse.
- Same key, rk_ready low for 5 cycles at rk_round=3 -> rk_data and rk_round=3 stable throughout; the final keys are unchanged.
- start_valid pulsed at rk_round=4 -> ignored; sequence continues to 10, and start_ready=0 during RUN.
- rst_n low at rk_round=6 -> immediately rk_valid=0, busy=0, rk_round=0; a new start with an all-zero key gives round 1 = 62 63 63 63 62 63 63 63 62 63 63 63 62 63 63 63.
- Back-to-back starts: the second start is accepted in the done cycle -> its round 0 appears on the next cycle, and rcon restarts at 01.
- With AES_KEY_SCHEDULE_CACHE_EN: after done, rd_idx=10 -> FIPS round 10 key; rd_idx=0 -> key_in; rd_idx=12 -> 0; cache_valid drops on the next start.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: round count, rcon seed, state typedefs and the GF(2^8) xtime helper.
package aes_pkg;

  localparam int unsigned AES_NR = 10;
  localparam logic [7:0]  AES_RCON_INIT = 8'h01;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_state_t;

  // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    logic [7:0] r;
    r = {b[6:0], 1'b0};
    if (b[7]) r = r ^ 8'h1b;
    return r;
  endfunction

endpackage

// File: rtl/aes_key_schedule_if.sv
// Start/round-key handshake bundle for aes_key_schedule.
// Carries the readback port pair and cache_valid when AES_KEY_SCHEDULE_CACHE_EN is defined.
interface aes_key_schedule_if;
  import aes_pkg::*;

  aes_state_t key_in;
  logic       start_valid;
  logic       start_ready;
  aes_state_t rk_data;
  logic [3:0] rk_round;
  logic       rk_valid;
  logic       rk_ready;
  logic       busy;
  logic       done;
`ifdef AES_KEY_SCHEDULE_CACHE_EN
  logic [3:0] rd_idx;
  aes_state_t rd_key;
  logic       cache_valid;

  modport master (
    output key_in, start_valid, rk_ready, rd_idx,
    input  start_ready, rk_data, rk_round, rk_valid, busy, done, rd_key, cache_valid
  );
  modport slave (
    input  key_in, start_valid, rk_ready, rd_idx,
    output start_ready, rk_data, rk_round, rk_valid, busy, done, rd_key, cache_valid
  );
`else
  modport master (
    output key_in, start_valid, rk_ready,
    input  start_ready, rk_data, rk_round, rk_valid, busy, done
  );
  modport slave (
    input  key_in, start_valid, rk_ready,
    output start_ready, rk_data, rk_round, rk_valid, busy, done
  );
`endif

endinterface

// File: rtl/aes_sbox.sv
// Forward AES S-box, pure combinational lookup; shared by SubWord and SubBytes.
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [7:0] SboxTbl [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_o = SboxTbl[in_i];

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 key expansion streaming round keys 0..10 over a valid/ready handshake.
// Optional round-key cache with combinational readback: define AES_KEY_SCHEDULE_CACHE_EN.
module aes_key_schedule
  import aes_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  aes_key_schedule_if.slave ks
);

  localparam int unsigned NR        = AES_NR;
  localparam logic [3:0]  LastRound = 4'(NR);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e     state_q, state_d;
  aes_state_t rk_data_q, rk_data_d;
  logic [3:0] rk_round_q, rk_round_d;
  logic [7:0] rcon_q, rcon_d;
  logic       done_q, done_d;

  aes_word_t  w3, rot_word, sub_word, t_word;
  aes_word_t  nw0, nw1, nw2, nw3;
  aes_state_t next_key;
  logic       rk_hs;

  assign w3       = rk_data_q[127:96];
  assign rot_word = {w3[7:0], w3[31:8]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .in_i  (rot_word[i*8 +: 8]),
      .out_o (sub_word[i*8 +: 8])
    );
  end

  assign t_word   = sub_word ^ {24'h0, rcon_q};
  assign nw0      = rk_data_q[31:0]   ^ t_word;
  assign nw1      = rk_data_q[63:32]  ^ nw0;
  assign nw2      = rk_data_q[95:64]  ^ nw1;
  assign nw3      = rk_data_q[127:96] ^ nw2;
  assign next_key = {nw3, nw2, nw1, nw0};

  assign rk_hs = (state_q == StRun) && ks.rk_ready;

  always_comb begin
    state_d    = state_q;
    rk_data_d  = rk_data_q;
    rk_round_d = rk_round_q;
    rcon_d     = rcon_q;
    done_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ks.start_valid) begin
          state_d    = StRun;
          rk_data_d  = ks.key_in;
          rk_round_d = '0;
          rcon_d     = AES_RCON_INIT;
        end
      end
      StRun: begin
        if (ks.rk_ready) begin
          if (rk_round_q == LastRound) begin
            // Key 10 and its index stay visible after the run ends.
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            rk_data_d  = next_key;
            rk_round_d = rk_round_q + 4'd1;
            // The step into key 10 consumes 8'h36; rcon stops there.
            if (rk_round_q < LastRound - 4'd1) rcon_d = xtime(rcon_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      rk_data_q  <= '0;
      rk_round_q <= '0;
      rcon_q     <= AES_RCON_INIT;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rk_data_q  <= rk_data_d;
      rk_round_q <= rk_round_d;
      rcon_q     <= rcon_d;
      done_q     <= done_d;
    end
  end

  assign ks.start_ready = (state_q == StIdle);
  assign ks.rk_valid    = (state_q == StRun);
  assign ks.busy        = (state_q == StRun);
  assign ks.rk_data     = rk_data_q;
  assign ks.rk_round    = rk_round_q;
  assign ks.done        = done_q;

`ifdef AES_KEY_SCHEDULE_CACHE_EN
  aes_state_t cache_q [NR+1];
  logic       cache_valid_q, cache_valid_d;

  always_comb begin
    cache_valid_d = cache_valid_q;
    if (ks.start_valid && (state_q == StIdle)) cache_valid_d = 1'b0;
    else if (done_d)                           cache_valid_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= int'(NR); i++) cache_q[i] <= '0;
      cache_valid_q <= 1'b0;
    end else begin
      if (rk_hs) cache_q[rk_round_q] <= rk_data_q;
      cache_valid_q <= cache_valid_d;
    end
  end

  assign ks.rd_key      = (ks.rd_idx <= LastRound) ? cache_q[ks.rd_idx] : '0;
  assign ks.cache_valid = cache_valid_q;
`else
  logic unused_rk_hs;
  assign unused_rk_hs = rk_hs;
`endif

endmodule

// File: tb/tb_aes_key_schedule.sv
// Directed bench for aes_key_schedule: scoreboard of expected round keys from an independent model.
module tb_aes_key_schedule;

  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   round;
  } exp_t;
  exp_t sb[$];

  aes_key_schedule_if ks_if ();

  aes_key_schedule dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ks    (ks_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, required finish before 500us");
    $fatal(1, "watchdog");
  end

  // Byte 0 written leftmost, as in FIPS-197 listings.
  function automatic logic [127:0] be2st(input logic [127:0] be);
    logic [127:0] s;
    for (int i = 0; i < 16; i++) s[i*8 +: 8] = be[127-i*8 -: 8];
    return s;
  endfunction

  function automatic logic [7:0] m_xtime(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = m_xtime(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    logic [7:0] r = x;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box derived from field inverse plus affine map, not from a table.
  function automatic logic [7:0] sbox_m(input logic [7:0] b);
    logic [7:0] inv = 8'h00;
    for (int y = 1; y < 256; y++) if (gmul(b, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ rl(inv, 1) ^ rl(inv, 2) ^ rl(inv, 3) ^ rl(inv, 4) ^ 8'h63;
  endfunction

  task automatic push_expansion(input logic [127:0] key);
    logic [127:0] cur = key;
    logic [7:0]   rcon = 8'h01;
    logic [31:0]  w3, rot, t;
    logic [31:0]  w [4];
    for (int r = 0; r <= 10; r++) begin
      sb.push_back('{data: cur, round: 4'(r)});
      w3  = cur[127:96];
      rot = {w3[7:0], w3[31:8]};
      for (int b = 0; b < 4; b++) t[b*8 +: 8] = sbox_m(rot[b*8 +: 8]);
      t    = t ^ {24'h0, rcon};
      w[0] = cur[31:0] ^ t;
      w[1] = cur[63:32] ^ w[0];
      w[2] = cur[95:64] ^ w[1];
      w[3] = cur[127:96] ^ w[2];
      cur  = {w[3], w[2], w[1], w[0]};
      rcon = m_xtime(rcon);
    end
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check any handshake about to happen, then advance to the next falling edge.
  task automatic cyc();
    exp_t e;
    if (ks_if.rk_valid === 1'b1 && ks_if.rk_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 128'(sb.size()), 128'd1);
      end else begin
        e = sb.pop_front();
        chk("sb_key", ks_if.rk_data, e.data);
        chk("sb_round", 128'(ks_if.rk_round), 128'(e.round));
      end
    end
    @(negedge clk);
  endtask

  task automatic do_start(input logic [127:0] key);
    ks_if.key_in      = key;
    ks_if.start_valid = 1'b1;
    chk("start_ready_idle", 128'(ks_if.start_ready), 128'd1);
    push_expansion(key);
    cyc();
    ks_if.start_valid = 1'b0;
    chk("first_valid", 128'(ks_if.rk_valid), 128'd1);
    chk("first_busy", 128'(ks_if.busy), 128'd1);
    chk("first_round", 128'(ks_if.rk_round), 128'd0);
    chk("first_key", ks_if.rk_data, key);
  endtask

  task automatic wait_round(input logic [3:0] r);
    int n = 0;
    while (ks_if.rk_round !== r && n < 64) begin
      cyc();
      n++;
    end
    chk("wait_round", 128'(ks_if.rk_round), 128'(r));
  endtask

  task automatic wait_done();
    int n = 0;
    while (ks_if.done !== 1'b1 && n < 64) begin
      cyc();
      n++;
    end
    chk("wait_done", 128'(ks_if.done), 128'd1);
  endtask

  logic [127:0] fips_key, fips_r1, fips_r10, zero_r1, rnd_key;

  initial begin
    fips_key = be2st(128'h2b7e151628aed2a6abf7158809cf4f3c);
    fips_r1  = be2st(128'ha0fafe1788542cb123a339392a6c7605);
    fips_r10 = be2st(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    zero_r1  = be2st(128'h62636363626363636263636362636363);
    rnd_key  = {$urandom, $urandom, $urandom, $urandom};

    rst_n             = 1'b0;
    ks_if.key_in      = '0;
    ks_if.start_valid = 1'b0;
    ks_if.rk_ready    = 1'b0;
`ifdef AES_KEY_SCHEDULE_CACHE_EN
    ks_if.rd_idx      = '0;
`endif
    @(negedge clk);
    chk("rst_valid", 128'(ks_if.rk_valid), 128'd0);
    chk("rst_busy", 128'(ks_if.busy), 128'd0);
    chk("rst_done", 128'(ks_if.done), 128'd0);
    chk("rst_round", 128'(ks_if.rk_round), 128'd0);
    chk("rst_data", ks_if.rk_data, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_start_ready", 128'(ks_if.start_ready), 128'd1);

    // FIPS-197 key, consumer always ready.
    ks_if.rk_ready = 1'b1;
    do_start(fips_key);
    for (int i = 0; i <= 10; i++) begin
      chk("run_valid", 128'(ks_if.rk_valid), 128'd1);
      if (i == 1)  chk("fips_round1", ks_if.rk_data, fips_r1);
      if (i == 10) chk("fips_round10", ks_if.rk_data, fips_r10);
      cyc();
    end
    chk("done_pulse", 128'(ks_if.done), 128'd1);
    chk("done_valid", 128'(ks_if.rk_valid), 128'd0);
    chk("done_busy", 128'(ks_if.busy), 128'd0);
    chk("done_round", 128'(ks_if.rk_round), 128'd10);
    chk("done_data", ks_if.rk_data, fips_r10);
    cyc();
    chk("done_one_cycle", 128'(ks_if.done), 128'd0);

`ifdef AES_KEY_SCHEDULE_CACHE_EN
    chk("cache_valid_set", 128'(ks_if.cache_valid), 128'd1);
    ks_if.rd_idx = 4'd10;
    #1 chk("cache_rd10", ks_if.rd_key, fips_r10);
    ks_if.rd_idx = 4'd0;
    #1 chk("cache_rd0", ks_if.rd_key, fips_key);
    ks_if.rd_idx = 4'd12;
    #1 chk("cache_rd12", ks_if.rd_key, 128'd0);
`endif

    // Stall five cycles at round 3.
    do_start(fips_key);
`ifdef AES_KEY_SCHEDULE_CACHE_EN
    chk("cache_valid_clr", 128'(ks_if.cache_valid), 128'd0);
`endif
    wait_round(4'd3);
    ks_if.rk_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_round", 128'(ks_if.rk_round), 128'd3);
      chk("stall_data", ks_if.rk_data, sb[0].data);
      chk("stall_valid", 128'(ks_if.rk_valid), 128'd1);
    end
    ks_if.rk_ready = 1'b1;

    // Start pulse mid-run must be ignored.
    wait_round(4'd4);
    ks_if.start_valid = 1'b1;
    ks_if.key_in      = rnd_key;
    chk("start_ready_run", 128'(ks_if.start_ready), 128'd0);
    cyc();
    ks_if.start_valid = 1'b0;
    chk("ignored_start_round", 128'(ks_if.rk_round), 128'd5);
    wait_done();
    chk("stall_final_key", ks_if.rk_data, fips_r10);

    // Reset mid-expansion, then an all-zero key.
    cyc();
    do_start(fips_key);
    wait_round(4'd6);
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 128'(ks_if.rk_valid), 128'd0);
    chk("abort_busy", 128'(ks_if.busy), 128'd0);
    chk("abort_round", 128'(ks_if.rk_round), 128'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start(128'd0);
    cyc();
    chk("zero_round1", ks_if.rk_data, zero_r1);
    wait_done();

    // Back-to-back: second start taken in the done cycle.
    do_start(rnd_key);
    wait_done();
    do_start(fips_key);
    wait_done();
    chk("b2b_final_key", ks_if.rk_data, fips_r10);
    cyc();

    chk("sb_empty", 128'(sb.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
